// File: rtl/sdf_bf_if.sv
// Complex sample stream between SDF FFT stages.
// One word per cycle when valid is high; sop marks a frame start.
interface sdf_bf_if #(
  parameter int WIDTH = 16
);
  logic                    valid;
  logic                    sop;
  logic signed [WIDTH-1:0] re;
  logic signed [WIDTH-1:0] im;

  modport master (output valid, sop, re, im);
  modport slave  (input  valid, sop, re, im);
endinterface

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Stallable on valid; optional -j rotation for BF2II use.
module sdf_bf_stage #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int SCALE       = 1,
  parameter int TRIVIAL_MUL = 0
) (
  input  logic     clk,
  input  logic     rst,
  sdf_bf_if.slave  in_s,
  sdf_bf_if.master out_m
);

  localparam int LD = $clog2(DEPTH);
  localparam int CW = LD + 1 + ((TRIVIAL_MUL != 0) ? 1 : 0);

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [WIDTH:0]   wide_t;

  localparam word_t MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t MINV = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic word_t neg_sat(input word_t x);
    return (x == MINV) ? MAXV : -x;
  endfunction

  function automatic word_t fit(input wide_t x);
    if (SCALE != 0)
      return x[WIDTH:1];
    if (x[WIDTH] != x[WIDTH-1])
      return x[WIDTH] ? MINV : MAXV;
    return x[WIDTH-1:0];
  endfunction

  logic [CW-1:0] cnt;
  logic [LD:0]   low;
  logic          primed;
  logic          h;
  logic          accept;
  logic          quad;

  assign low    = cnt[LD:0];
  assign h      = cnt[LD];
  assign accept = in_s.valid & ~rst;

  // Last quarter of the 4*DEPTH block gets the -j rotation
  generate
    if (TRIVIAL_MUL != 0) begin : g_tm
      assign quad = &cnt[CW-1:CW-2];
    end else begin : g_no_tm
      assign quad = 1'b0;
    end
  endgenerate

  logic [2*WIDTH-1:0] dl [DEPTH];

  word_t x_re, x_im;
  word_t d_re, d_im;
  word_t p_re, p_im;
  word_t c_re, c_im;
  wide_t s_re, s_im;
  wide_t t_re, t_im;

  always_comb begin
    x_re = quad ? in_s.im : in_s.re;
    x_im = quad ? neg_sat(in_s.re) : in_s.im;
    d_re = dl[DEPTH-1][2*WIDTH-1:WIDTH];
    d_im = dl[DEPTH-1][WIDTH-1:0];
    s_re = {d_re[WIDTH-1], d_re} + {x_re[WIDTH-1], x_re};
    s_im = {d_im[WIDTH-1], d_im} + {x_im[WIDTH-1], x_im};
    t_re = {d_re[WIDTH-1], d_re} - {x_re[WIDTH-1], x_re};
    t_im = {d_im[WIDTH-1], d_im} - {x_im[WIDTH-1], x_im};
    p_re = h ? fit(t_re) : x_re;
    p_im = h ? fit(t_im) : x_im;
    c_re = h ? fit(s_re) : d_re;
    c_im = h ? fit(s_im) : d_im;
  end

  // Delay line is not reset: nothing reaches the output before primed
  always_ff @(posedge clk) begin
    if (accept) begin
      dl[0] <= {p_re, p_im};
      for (int i = 1; i < DEPTH; i++)
        dl[i] <= dl[i-1];
    end
  end

  logic  o_valid;
  logic  o_sop;
  word_t o_re;
  word_t o_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      primed  <= 1'b0;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
    end else begin
      o_valid <= accept & (primed | h);
      o_sop   <= accept & h &
                 (low == (LD+1)'(DEPTH));
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (&low)
          primed <= 1'b1;
        if (primed | h) begin
          o_re <= c_re;
          o_im <= c_im;
        end
      end
    end
  end

  assign out_m.valid = o_valid;
  assign out_m.sop   = o_sop;
  assign out_m.re    = o_re;
  assign out_m.im    = o_im;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage across several parameter sets.
// Outputs are queued on the falling edge and compared to hand values.
module tb_sdf_bf_stage;

  logic        clk;
  logic        rst;
  logic        v;
  logic [15:0] xr;
  logic [15:0] xi;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [32:0] smp_t;
  smp_t qa[$], qb[$], qc[$], qd[$];

  sdf_bf_if #(.WIDTH(16)) a_i(), a_o();
  sdf_bf_if #(.WIDTH(16)) b_i(), b_o();
  sdf_bf_if #(.WIDTH(16)) c_i(), c_o();
  sdf_bf_if #(.WIDTH(16)) d_i(), d_o();

  assign a_i.valid = v;
  assign a_i.sop   = 1'b0;
  assign a_i.re    = xr;
  assign a_i.im    = xi;
  assign b_i.valid = v;
  assign b_i.sop   = 1'b0;
  assign b_i.re    = xr;
  assign b_i.im    = xi;
  assign c_i.valid = v;
  assign c_i.sop   = 1'b0;
  assign c_i.re    = xr;
  assign c_i.im    = xi;
  assign d_i.valid = v;
  assign d_i.sop   = 1'b0;
  assign d_i.re    = xr;
  assign d_i.im    = xi;

  sdf_bf_stage #(.WIDTH(16), .DEPTH(4), .SCALE(0), .TRIVIAL_MUL(0))
    u_a (.clk(clk), .rst(rst), .in_s(a_i), .out_m(a_o));
  sdf_bf_stage #(.WIDTH(16), .DEPTH(1), .SCALE(0), .TRIVIAL_MUL(0))
    u_b (.clk(clk), .rst(rst), .in_s(b_i), .out_m(b_o));
  sdf_bf_stage #(.WIDTH(16), .DEPTH(1), .SCALE(1), .TRIVIAL_MUL(0))
    u_c (.clk(clk), .rst(rst), .in_s(c_i), .out_m(c_o));
  sdf_bf_stage #(.WIDTH(16), .DEPTH(2), .SCALE(0), .TRIVIAL_MUL(1))
    u_d (.clk(clk), .rst(rst), .in_s(d_i), .out_m(d_o));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_o.valid) qa.push_back({a_o.sop, a_o.re, a_o.im});
    if (b_o.valid) qb.push_back({b_o.sop, b_o.re, b_o.im});
    if (c_o.valid) qc.push_back({c_o.sop, c_o.re, c_o.im});
    if (d_o.valid) qd.push_back({d_o.sop, d_o.re, d_o.im});
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic vv,
                     input logic [15:0] r,
                     input logic [15:0] i);
    v  = vv;
    xr = r;
    xi = i;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa.delete();
    qb.delete();
    qc.delete();
    qd.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 16'h0, 16'h0);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic feed_t1(input bit toggle);
    logic [15:0] r;
    for (int k = 1; k <= 12; k++) begin
      r = (k <= 8) ? 16'(k) : 16'h0;
      cyc(1, r, 16'h0);
      if (toggle) begin
        chk($sformatf("t2_vld_on%0d", k),
            {15'b0, a_o.valid}, (k >= 5) ? 16'd1 : 16'd0);
        cyc(0, 16'h0, 16'h0);
        chk($sformatf("t2_vld_off%0d", k),
            {15'b0, a_o.valid}, 16'd0);
      end
    end
    cyc(0, 16'h0, 16'h0);
  endtask

  task automatic check_seq(input string tag,
                           input int sel,
                           input int n,
                           input int er[8],
                           input int ei[8],
                           input bit es[8]);
    smp_t q[$];
    case (sel)
      0:       q = qa;
      1:       q = qb;
      2:       q = qc;
      default: q = qd;
    endcase
    chk({tag, "_cnt"}, 16'(q.size()), 16'(n));
    for (int k = 0; k < n; k++) begin
      if (k < q.size()) begin
        chk($sformatf("%s_re%0d", tag, k), q[k][31:16], 16'(er[k]));
        chk($sformatf("%s_im%0d", tag, k), q[k][15:0], 16'(ei[k]));
        chk($sformatf("%s_sop%0d", tag, k),
            {15'b0, q[k][32]}, {15'b0, es[k]});
      end
    end
  endtask

  int t1_re[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
  int zero8[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  bit t1_sop[8] = '{1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    v   = 1'b0;
    xr  = '0;
    xi  = '0;

    do_reset();
    chk("rst_vld", {15'b0, a_o.valid}, 16'd0);
    chk("rst_sop", {15'b0, a_o.sop}, 16'd0);
    chk("rst_re", a_o.re, 16'd0);
    chk("rst_im_d", d_o.im, 16'd0);

    // continuous ramp plus flush
    feed_t1(0);
    check_seq("t1", 0, 8, t1_re, zero8, t1_sop);

    // stalled every other cycle
    do_reset();
    feed_t1(1);
    check_seq("t2", 0, 8, t1_re, zero8, t1_sop);

    // overflow handling, DEPTH=1, saturate and scale
    do_reset();
    cyc(1, 16'h7FFF, 16'h0);
    cyc(1, 16'h7FFF, 16'h0);
    cyc(1, 16'h8000, 16'h0);
    cyc(1, 16'h7FFF, 16'h0);
    cyc(1, 16'h0000, 16'h0);
    cyc(0, 16'h0000, 16'h0);
    check_seq("t3sat", 1, 4,
              '{32'h7FFF, 0, 32'hFFFF, 32'h8000, 0, 0, 0, 0},
              zero8, '{1, 0, 1, 0, 0, 0, 0, 0});
    check_seq("t3scl", 2, 4,
              '{32'h7FFF, 0, 32'hFFFF, 32'h8000, 0, 0, 0, 0},
              zero8, '{1, 0, 1, 0, 0, 0, 0, 0});

    // -j rotation on the last quarter
    do_reset();
    for (int k = 0; k < 8; k++)
      cyc(1, 16'd3, 16'd1);
    cyc(1, 16'd0, 16'd0);
    cyc(1, 16'd0, 16'd0);
    cyc(0, 16'd0, 16'd0);
    check_seq("t4", 3, 8,
              '{6, 6, 0, 0, 4, 4, 2, 2},
              '{2, 2, 0, 0, -2, -2, 4, 4},
              '{1, 0, 0, 0, 1, 0, 0, 0});

    // reset in the middle of the second frame
    do_reset();
    for (int k = 1; k <= 8; k++)
      cyc(1, 16'(k), 16'h0);
    for (int k = 1; k <= 3; k++)
      cyc(1, 16'(k), 16'h0);
    chk("t5_pre_vld", {15'b0, a_o.valid}, 16'd1);
    rst = 1'b1;
    cyc(1, 16'd4, 16'h0);
    chk("t5_rst_vld", {15'b0, a_o.valid}, 16'd0);
    chk("t5_rst_re", a_o.re, 16'd0);
    rst = 1'b0;
    clear_q();
    feed_t1(0);
    check_seq("t5", 0, 8, t1_re, zero8, t1_sop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
